// File: rtl/trace_command_receiver.sv
// trace_command_receiver
//   Receives L1 requests and snooped bus ops over valid/ready handshakes, decodes
//   their ASCII opcodes to 3-bit command codes, queues {cmd,addr} in a FIFO and
//   presents the head to the L2 controller. Optional per-command statistics.
//
// Configuration macro: STATS_EN (defined -> 8 saturating counters, else statCount = 0)
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   L1Valid/L1Ready             L1 request handshake (L1Address, L1Operation "DR"/"DW"/"IR")
//   snoopValid/snoopReady       snoop handshake (sharedAddress, sharedOperation "I"/"R"/"W"/"M")
//   clearCmd                    sync flush of FIFO and statistics
//   reqValid/reqReady           head handshake towards controller (reqCmd, reqAddr)
//   statSel/statCount           statistics read port (0..6 cmd, 7 illegal), combinational
module trace_command_receiver #(
    parameter int unsigned addressSize = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned countWidth  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   L1Valid,
    output logic                   L1Ready,
    input  logic [addressSize-1:0] L1Address,
    input  logic [15:0]            L1Operation,
    input  logic                   snoopValid,
    output logic                   snoopReady,
    input  logic [addressSize-1:0] sharedAddress,
    input  logic [7:0]             sharedOperation,
    input  logic                   clearCmd,
    output logic                   reqValid,
    input  logic                   reqReady,
    output logic [2:0]             reqCmd,
    output logic [addressSize-1:0] reqAddr,
    input  logic [2:0]             statSel,
    output logic [countWidth-1:0]  statCount
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [2:0]             r_mem_cmd  [DEPTH];
    logic [addressSize-1:0] r_mem_addr [DEPTH];

    logic                   w_full;
    logic                   w_empty;
    logic                   w_snoop_fire;
    logic                   w_l1_fire;
    logic                   w_fire;
    logic [2:0]             w_l1_cmd;
    logic                   w_l1_legal;
    logic [2:0]             w_snoop_cmd;
    logic                   w_snoop_legal;
    logic [2:0]             w_cmd;
    logic                   w_legal;
    logic [addressSize-1:0] w_addr;
    logic                   w_push;
    logic                   w_pop;

    // ASCII opcode decode for both sources
    always_comb begin
        w_l1_cmd      = 3'd0;
        w_l1_legal    = 1'b1;
        w_snoop_cmd   = 3'd0;
        w_snoop_legal = 1'b1;
        case (L1Operation)
            16'h4452: w_l1_cmd = 3'd0;   // "DR"
            16'h4457: w_l1_cmd = 3'd1;   // "DW"
            16'h4952: w_l1_cmd = 3'd2;   // "IR"
            default:  w_l1_legal = 1'b0;
        endcase
        case (sharedOperation)
            8'h49:   w_snoop_cmd = 3'd3; // "I"
            8'h52:   w_snoop_cmd = 3'd4; // "R"
            8'h57:   w_snoop_cmd = 3'd5; // "W"
            8'h4D:   w_snoop_cmd = 3'd6; // "M"
            default: w_snoop_legal = 1'b0;
        endcase
    end

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // Snoop has priority; L1 is only offered a slot when no snoop is presented
    assign snoopReady = !w_full && !clearCmd;
    assign L1Ready    = !w_full && !clearCmd && !snoopValid;

    assign w_snoop_fire = snoopValid && snoopReady;
    assign w_l1_fire    = L1Valid && L1Ready;
    assign w_fire       = w_snoop_fire || w_l1_fire;
    assign w_cmd        = w_snoop_fire ? w_snoop_cmd   : w_l1_cmd;
    assign w_legal      = w_snoop_fire ? w_snoop_legal : w_l1_legal;
    assign w_addr       = w_snoop_fire ? sharedAddress : L1Address;
    assign w_push       = w_fire && w_legal;
    assign w_pop        = !w_empty && reqReady && !clearCmd;

    // FIFO pointers and occupancy; clear wins over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clearCmd) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_cmd[r_wr_ptr]  <= w_cmd;
            r_mem_addr[r_wr_ptr] <= w_addr;
        end
    end

    assign reqValid = !w_empty;
    assign reqCmd   = w_empty ? 3'd0 : r_mem_cmd[r_rd_ptr];
    assign reqAddr  = w_empty ? '0   : r_mem_addr[r_rd_ptr];

`ifdef STATS_EN
    logic [countWidth-1:0] r_stat [8];
    logic [2:0]            w_stat_idx;

    // Illegal ops share slot 7
    assign w_stat_idx = w_legal ? w_cmd : 3'd7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_stat[i] <= '0;
        end else if (clearCmd) begin
            for (int i = 0; i < 8; i++) r_stat[i] <= '0;
        end else if (w_fire && (r_stat[w_stat_idx] != '1)) begin
            r_stat[w_stat_idx] <= r_stat[w_stat_idx] + countWidth'(1);
        end
    end

    assign statCount = r_stat[statSel];
`else
    logic w_unused_stat_sel;
    assign w_unused_stat_sel = ^statSel;
    assign statCount         = '0;
`endif

endmodule

// File: tb/tb_trace_command_receiver.sv
module tb_trace_command_receiver;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 32;
`ifdef STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    localparam logic [15:0] OP_DR = "DR";
    localparam logic [15:0] OP_DW = "DW";
    localparam logic [15:0] OP_IR = "IR";
    localparam logic [15:0] OP_XX = "XX";
    localparam logic [7:0]  OP_I  = "I";
    localparam logic [7:0]  OP_R  = "R";
    localparam logic [7:0]  OP_W  = "W";
    localparam logic [7:0]  OP_M  = "M";
    localparam logic [7:0]  OP_Z  = "Z";

    // Bit positions inside the observation vector
    localparam int SR_B = 69;
    localparam int LR_B = 68;
    localparam int RV_B = 67;

    logic          clk;
    logic          rst_n;
    logic          L1Valid;
    logic          L1Ready;
    logic [AW-1:0] L1Address;
    logic [15:0]   L1Operation;
    logic          snoopValid;
    logic          snoopReady;
    logic [AW-1:0] sharedAddress;
    logic [7:0]    sharedOperation;
    logic          clearCmd;
    logic          reqValid;
    logic          reqReady;
    logic [2:0]    reqCmd;
    logic [AW-1:0] reqAddr;
    logic [2:0]    statSel;
    logic [CW-1:0] statCount;

    trace_command_receiver #(
        .addressSize(AW),
        .DEPTH      (DEPTH),
        .countWidth (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .L1Valid        (L1Valid),
        .L1Ready        (L1Ready),
        .L1Address      (L1Address),
        .L1Operation    (L1Operation),
        .snoopValid     (snoopValid),
        .snoopReady     (snoopReady),
        .sharedAddress  (sharedAddress),
        .sharedOperation(sharedOperation),
        .clearCmd       (clearCmd),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqCmd         (reqCmd),
        .reqAddr        (reqAddr),
        .statSel        (statSel),
        .statCount      (statCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [34:0] entry_t;

    // Reference model: an ordered queue of entries plus eight counters
    entry_t        mq[$];
    logic [CW-1:0] mstat [8];
    entry_t        dut_popped[$];
    entry_t        mod_popped[$];

    logic [69:0]   obs_vec;
    logic [69:0]   exp_vec;
    bit            m_l1_fire;
    bit            m_s_fire;
    int            n_checks;
    int            n_fail;

    function automatic int dec_l1(input logic [15:0] op);
        if (op == OP_DR) return 0;
        if (op == OP_DW) return 1;
        if (op == OP_IR) return 2;
        return -1;
    endfunction

    function automatic int dec_snoop(input logic [7:0] op);
        if (op == OP_I) return 3;
        if (op == OP_R) return 4;
        if (op == OP_W) return 5;
        if (op == OP_M) return 6;
        return -1;
    endfunction

    function automatic logic [15:0] l1_pick(input int k);
        case (k)
            0:       return OP_DR;
            1:       return OP_DW;
            2:       return OP_IR;
            default: return OP_XX;
        endcase
    endfunction

    function automatic logic [7:0] snoop_pick(input int k);
        case (k)
            0:       return OP_I;
            1:       return OP_R;
            2:       return OP_W;
            3:       return OP_M;
            default: return OP_Z;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < 8; i++) mstat[i] = '0;
    endtask

    task automatic bump(input int idx);
        if (mstat[idx] != '1) mstat[idx] = mstat[idx] + CW'(1);
    endtask

    task automatic idle();
        L1Valid         = 1'b0;
        snoopValid      = 1'b0;
        reqReady        = 1'b0;
        clearCmd        = 1'b0;
        statSel         = 3'd0;
        L1Operation     = OP_DR;
        sharedOperation = OP_I;
        L1Address       = '0;
        sharedAddress   = '0;
    endtask

    // One clock: sample outputs mid-cycle against the model, then advance both
    task automatic cycle();
        int     code;
        bit     full, sr, lr, sf, lf, pop;
        entry_t head;
        #1;
        full = (mq.size() == DEPTH);
        sr   = !full && !clearCmd;
        lr   = sr && !snoopValid;
        head = (mq.size() != 0) ? mq[0] : '0;
        exp_vec = {sr, lr, (mq.size() != 0), head, (STATS_ON ? mstat[statSel] : CW'(0))};
        obs_vec = {snoopReady, L1Ready, reqValid, reqCmd, reqAddr, statCount};
        sf  = snoopValid && sr;
        lf  = L1Valid && lr;
        pop = (mq.size() != 0) && reqReady && !clearCmd;
        m_l1_fire = lf;
        m_s_fire  = sf;
        if (reqValid && reqReady && !clearCmd) dut_popped.push_back({reqCmd, reqAddr});
        @(posedge clk);
        if (clearCmd) begin
            model_clear();
        end else begin
            if (pop) mod_popped.push_back(mq.pop_front());
            if (sf || lf) begin
                code = sf ? dec_snoop(sharedOperation) : dec_l1(L1Operation);
                if (code >= 0) begin
                    mq.push_back({3'(code), (sf ? sharedAddress : L1Address)});
                    bump(code);
                end else begin
                    bump(7);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if ({reqValid, reqCmd, reqAddr} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_head: got v=%0b cmd=%0d addr=%h, want 0/0/0", reqValid, reqCmd, reqAddr);
        end
        n_checks++;
        if ({L1Ready, snoopReady} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready: got L1Ready=%0b snoopReady=%0b, want 1/1", L1Ready, snoopReady);
        end
        for (int s = 0; s < 8; s++) begin
            statSel = 3'(s);
            #1;
            n_checks++;
            if (statCount !== CW'(0)) begin
                n_fail++;
                $display("FAIL reset_stat sel=%0d: got %0d, want 0", s, statCount);
            end
        end
        statSel = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode();
        dut_popped.delete();
        idle();
        L1Valid = 1'b1; L1Operation = OP_DW; L1Address = 32'h0000_1A40;
        cycle();
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL decode_l1: got %h want %h", obs_vec, exp_vec); end
        idle();
        snoopValid = 1'b1; sharedOperation = OP_M; sharedAddress = 32'h0000_2000;
        cycle();
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL decode_snoop: got %h want %h", obs_vec, exp_vec); end
        idle();
        reqReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL decode_pop%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        idle();
        n_checks++;
        if (dut_popped.size() != 2) begin
            n_fail++;
            $display("FAIL decode_count: got %0d pops, want 2", dut_popped.size());
        end else if (dut_popped[0] !== {3'd1, 32'h0000_1A40} || dut_popped[1] !== {3'd6, 32'h0000_2000}) begin
            n_fail++;
            $display("FAIL decode_order: got %h,%h want %h,%h", dut_popped[0], dut_popped[1],
                     {3'd1, 32'h0000_1A40}, {3'd6, 32'h0000_2000});
        end
    endtask

    task automatic test_collision();
        dut_popped.delete();
        idle();
        L1Valid = 1'b1; L1Operation = OP_DR; L1Address = 32'h10;
        snoopValid = 1'b1; sharedOperation = OP_R; sharedAddress = 32'h20;
        cycle();
        n_checks++;
        if (obs_vec[LR_B] !== 1'b0 || obs_vec[SR_B] !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_ready: got L1Ready=%0b snoopReady=%0b, want 0/1", obs_vec[LR_B], obs_vec[SR_B]);
        end
        snoopValid = 1'b0;
        cycle();
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL collision_l1: got %h want %h", obs_vec, exp_vec); end
        idle();
        reqReady = 1'b1;
        cycle();
        cycle();
        idle();
        n_checks++;
        if (dut_popped.size() != 2) begin
            n_fail++;
            $display("FAIL collision_count: got %0d pops, want 2", dut_popped.size());
        end else if (dut_popped[0] !== {3'd4, 32'h20} || dut_popped[1] !== {3'd0, 32'h10}) begin
            n_fail++;
            $display("FAIL collision_order: got %h,%h want %h,%h", dut_popped[0], dut_popped[1],
                     {3'd4, 32'h20}, {3'd0, 32'h10});
        end
    endtask

    task automatic test_full();
        dut_popped.delete();
        mod_popped.delete();
        idle();
        L1Valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            L1Operation = i[0] ? OP_DW : OP_DR;
            L1Address   = 32'(i * 32'h100);
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL full_fill%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        L1Address = 32'h900;
        // Full: pop only; then push+pop at 7; then push back to 8; then blocked
        for (int i = 0; i < 4; i++) begin
            reqReady = (i < 2);
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL full_step%0d: got %h want %h", i, obs_vec, exp_vec); end
            if (i == 0 || i == 3) begin
                n_checks++;
                if (obs_vec[LR_B] !== 1'b0 || obs_vec[RV_B] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_block%0d: got L1Ready=%0b reqValid=%0b, want 0/1", i, obs_vec[LR_B], obs_vec[RV_B]);
                end
            end
            if (m_l1_fire) L1Address = L1Address + 32'h100;
        end
        n_checks++;
        if (mq.size() != 8) begin n_fail++; $display("FAIL full_model_depth: got %0d want 8", mq.size()); end
        idle();
        reqReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL full_drain%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        idle();
        n_checks++;
        if (dut_popped.size() != 10 || dut_popped != mod_popped) begin
            n_fail++;
            $display("FAIL full_order: got %0d pops, want 10 matching the model (%0d)", dut_popped.size(), mod_popped.size());
        end
    endtask

    task automatic test_wrap();
        int pushes;
        dut_popped.delete();
        mod_popped.delete();
        idle();
        pushes = 0;
        for (int i = 0; i < 60 && pushes < 20; i++) begin
            snoopValid      = 1'b1;
            sharedOperation = snoop_pick(int'($urandom_range(0, 3)));
            sharedAddress   = $urandom;
            reqReady        = (i % 4 != 0);
            cycle();
            if (m_s_fire) pushes++;
            n_checks++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL wrap_push%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        idle();
        reqReady = 1'b1;
        for (int i = 0; i < 16 && mq.size() != 0; i++) begin
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL wrap_drain%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        idle();
        n_checks++;
        if (pushes != 20 || dut_popped.size() != 20 || dut_popped != mod_popped) begin
            n_fail++;
            $display("FAIL wrap_order: pushes=%0d pops=%0d, want 20/20 matching the model", pushes, dut_popped.size());
        end
    endtask

    task automatic test_illegal_clear();
        idle();
        clearCmd = 1'b1;
        cycle();
        idle();
        L1Valid = 1'b1; L1Operation = OP_XX; L1Address = 32'h44;
        cycle();
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL illegal_accept: got %h want %h", obs_vec, exp_vec); end
        idle();
        statSel = 3'd7;
        cycle();
        n_checks++;
        if (obs_vec[RV_B] !== 1'b0 || statCount !== (STATS_ON ? CW'(1) : CW'(0))) begin
            n_fail++;
            $display("FAIL illegal_stat: got reqValid=%0b count=%0d, want 0/%0d", obs_vec[RV_B], statCount, STATS_ON ? 1 : 0);
        end
        idle();
        L1Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            L1Operation = l1_pick(i);
            L1Address   = 32'(32'h300 + i);
            cycle();
        end
        idle();
        clearCmd = 1'b1;
        reqReady = 1'b1;
        L1Valid  = 1'b1;
        snoopValid = 1'b1;
        cycle();
        n_checks++;
        if (obs_vec[LR_B] !== 1'b0 || obs_vec[SR_B] !== 1'b0 || obs_vec[RV_B] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_ready: got L1Ready=%0b snoopReady=%0b reqValid=%0b, want 0/0/1",
                     obs_vec[LR_B], obs_vec[SR_B], obs_vec[RV_B]);
        end
        idle();
        for (int s = 0; s < 8; s++) begin
            statSel = 3'(s);
            cycle();
            n_checks++;
            if (obs_vec[RV_B] !== 1'b0 || statCount !== CW'(0)) begin
                n_fail++;
                $display("FAIL clear_state sel=%0d: got reqValid=%0b count=%0d, want 0/0", s, obs_vec[RV_B], statCount);
            end
        end
        idle();
    endtask

    task automatic test_random();
        dut_popped.delete();
        mod_popped.delete();
        idle();
        m_l1_fire = 1'b1;
        for (int i = 0; i < 400; i++) begin
            // L1 request stays stable until it has been accepted
            if (!L1Valid || m_l1_fire) begin
                L1Valid     = 1'($urandom_range(0, 1));
                L1Operation = l1_pick(int'($urandom_range(0, 3)));
                L1Address   = $urandom;
            end
            snoopValid      = ($urandom_range(0, 2) == 0);
            sharedOperation = snoop_pick(int'($urandom_range(0, 4)));
            sharedAddress   = $urandom;
            reqReady        = 1'($urandom_range(0, 1));
            clearCmd        = ($urandom_range(0, 39) == 0);
            statSel         = 3'($urandom_range(0, 7));
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        idle();
        n_checks++;
        if (dut_popped != mod_popped) begin
            n_fail++;
            $display("FAIL random_order: got %0d pops, want %0d matching the model", dut_popped.size(), mod_popped.size());
        end
    endtask

    task automatic test_async_reset();
        idle();
        L1Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            L1Operation = OP_IR;
            L1Address   = 32'(32'h500 + i);
            cycle();
        end
        idle();
        rst_n = 1'b0;
        #2;
        model_clear();
        n_checks++;
        if ({reqValid, reqCmd, reqAddr} !== 36'd0 || statCount !== CW'(0)) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b cmd=%0d addr=%h stat=%0d, want all 0", reqValid, reqCmd, reqAddr, statCount);
        end
        rst_n = 1'b1;
        #1;
        reqReady = 1'b1;
        cycle();
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL async_after: got %h want %h", obs_vec, exp_vec); end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_decode();
        test_collision();
        test_full();
        test_wrap();
        test_illegal_clear();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
